axi_tb_mst: RTL and testbench

Single-outstanding AXI4 initiator for the testbench: the requesting end of the AXI4 memory-slave interface. Turns a simple command/response port into one-beat AXI4 write (AW/W/B) or read (AR/R) transactions, checks response IDs and `rlast`, and enforces a per-transaction timeout. Instantiated once per core port to drive the testbench memory model directly, without a core in the loop.

---
 rtl/axi_tb_pkg.sv | 17 +
 rtl/axi_tb_mst_if.sv | 66 ++++++
 rtl/axi_tb_mst.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_tb_mst.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tb_pkg.sv
// Shared types and AXI encodings for the testbench AXI4 initiator.
package axi_tb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    RD_REQ,
    RD_RSP,
    DONE
  } axi_mst_state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_tb_mst_if.sv
// AXI4 single-beat channel bundle between the testbench initiator and the memory slave.
interface axi_tb_mst_if #(
  parameter int TAGW = 1
);

  logic            awvalid;
  logic            awready;
  logic [31:0]     awaddr;
  logic [TAGW-1:0] awid;
  logic [7:0]      awlen;
  logic [1:0]      awburst;
  logic [2:0]      awsize;

  logic            wvalid;
  logic            wready;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;

  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [TAGW-1:0] bid;

  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [TAGW-1:0] arid;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic [2:0]      arsize;

  logic            rvalid;
  logic            rready;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic [TAGW-1:0] rid;
  logic            rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, awsize,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arburst, arsize,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst, awsize,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst, arsize,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );

endinterface

// File: rtl/axi_tb_mst.sv
// Single-outstanding AXI4 initiator: turns one command into a one-beat write or read,
// checks the returned ID and rlast, and aborts a transaction that outlives TIMEOUT cycles.
module axi_tb_mst
  import axi_tb_pkg::*;
#(
  parameter int TAGW    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic         aclk,
  input  logic         rst_l,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [31:0]  cmd_addr,
  input  logic [2:0]   cmd_size,
  input  logic [63:0]  cmd_wdata,
  input  logic [7:0]   cmd_wstrb,
  output logic         rsp_valid,
  output logic [63:0]  rsp_rdata,
  output logic [1:0]   rsp_resp,
  output logic         rsp_err,
  axi_tb_mst_if.master axi
);

  localparam int             TCW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT - 1);

  axi_mst_state_e state_q, state_d;

  logic            aw_done_q, aw_done_nx, w_done_q, w_done_nx;
  logic [TAGW-1:0] id_cnt_q, id_cnt_nx, cur_id_q, cur_id_nx;
  logic [TCW-1:0]  tcnt_q, tcnt_nx, tcnt_inc;

  logic            awvalid_q, awvalid_nx, wvalid_q, wvalid_nx, bready_q, bready_nx;
  logic            arvalid_q, arvalid_nx, rready_q, rready_nx;
  logic [31:0]     awaddr_q, awaddr_nx, araddr_q, araddr_nx;
  logic [TAGW-1:0] awid_q, awid_nx, arid_q, arid_nx;
  logic [2:0]      awsize_q, awsize_nx, arsize_q, arsize_nx;
  logic [63:0]     wdata_q, wdata_nx;
  logic [7:0]      wstrb_q, wstrb_nx;
  logic            rsp_valid_nx, rsp_err_nx;
  logic [63:0]     rsp_rdata_nx;
  logic [1:0]      rsp_resp_nx;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_both, tmo;

  assign aw_hs   = awvalid_q & axi.awready;
  assign w_hs    = wvalid_q  & axi.wready;
  assign b_hs    = bready_q  & axi.bvalid;
  assign ar_hs   = arvalid_q & axi.arready;
  assign r_hs    = rready_q  & axi.rvalid;
  assign wr_both = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  // The abort test looks at the count this cycle produces, so the response pulse lands TIMEOUT cycles after accept.
  assign tcnt_inc = tcnt_q + 1'b1;
  assign tmo      = (tcnt_inc == TLAST);

  assign cmd_ready   = (state_q == IDLE);
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awid    = awid_q;
  assign axi.awsize  = awsize_q;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = bready_q;
  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arid    = arid_q;
  assign axi.arsize  = arsize_q;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.rready  = rready_q;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A completing handshake always takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (wr_both) state_d = WR_RSP; else if (tmo) state_d = DONE;
      WR_RSP:  if (b_hs || tmo) state_d = DONE;
      RD_REQ:  if (ar_hs) state_d = RD_RSP; else if (tmo) state_d = DONE;
      RD_RSP:  if (r_hs || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    aw_done_nx   = aw_done_q;
    w_done_nx    = w_done_q;
    id_cnt_nx    = id_cnt_q;
    cur_id_nx    = cur_id_q;
    tcnt_nx      = tcnt_q;
    awvalid_nx   = awvalid_q;
    wvalid_nx    = wvalid_q;
    bready_nx    = bready_q;
    arvalid_nx   = arvalid_q;
    rready_nx    = rready_q;
    awaddr_nx    = awaddr_q;
    araddr_nx    = araddr_q;
    awid_nx      = awid_q;
    arid_nx      = arid_q;
    awsize_nx    = awsize_q;
    arsize_nx    = arsize_q;
    wdata_nx     = wdata_q;
    wstrb_nx     = wstrb_q;
    rsp_valid_nx = (state_d == DONE);
    rsp_rdata_nx = rsp_rdata;
    rsp_resp_nx  = rsp_resp;
    rsp_err_nx   = rsp_err;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          id_cnt_nx  = id_cnt_q + 1'b1;
          cur_id_nx  = id_cnt_q;
          tcnt_nx    = '0;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
          if (cmd_write) begin
            awvalid_nx = 1'b1;
            wvalid_nx  = 1'b1;
            awaddr_nx  = cmd_addr;
            awid_nx    = id_cnt_q;
            awsize_nx  = cmd_size;
            wdata_nx   = cmd_wdata;
            wstrb_nx   = cmd_wstrb;
          end else begin
            arvalid_nx = 1'b1;
            araddr_nx  = cmd_addr;
            arid_nx    = id_cnt_q;
            arsize_nx  = cmd_size;
          end
        end
      end
      WR_REQ: begin
        tcnt_nx    = tcnt_inc;
        aw_done_nx = aw_done_q | aw_hs;
        w_done_nx  = w_done_q | w_hs;
        if (aw_hs) awvalid_nx = 1'b0;
        if (w_hs)  wvalid_nx  = 1'b0;
        if (wr_both) begin
          bready_nx = 1'b1;
        end else if (tmo) begin
          awvalid_nx   = 1'b0;
          wvalid_nx    = 1'b0;
          rsp_err_nx   = 1'b1;
          rsp_resp_nx  = AXI_RESP_SLVERR;
          rsp_rdata_nx = '0;
        end
      end
      WR_RSP: begin
        tcnt_nx = tcnt_inc;
        if (b_hs) begin
          bready_nx    = 1'b0;
          rsp_rdata_nx = '0;
          rsp_resp_nx  = axi.bresp;
          rsp_err_nx   = (axi.bid != cur_id_q);
        end else if (tmo) begin
          bready_nx    = 1'b0;
          rsp_err_nx   = 1'b1;
          rsp_resp_nx  = AXI_RESP_SLVERR;
          rsp_rdata_nx = '0;
        end
      end
      RD_REQ: begin
        tcnt_nx = tcnt_inc;
        if (ar_hs) begin
          arvalid_nx = 1'b0;
          rready_nx  = 1'b1;
        end else if (tmo) begin
          arvalid_nx   = 1'b0;
          rsp_err_nx   = 1'b1;
          rsp_resp_nx  = AXI_RESP_SLVERR;
          rsp_rdata_nx = '0;
        end
      end
      RD_RSP: begin
        tcnt_nx = tcnt_inc;
        if (r_hs) begin
          rready_nx    = 1'b0;
          rsp_rdata_nx = axi.rdata;
          rsp_resp_nx  = axi.rresp;
          rsp_err_nx   = (axi.rid != cur_id_q) | ~axi.rlast;
        end else if (tmo) begin
          rready_nx    = 1'b0;
          rsp_err_nx   = 1'b1;
          rsp_resp_nx  = AXI_RESP_SLVERR;
          rsp_rdata_nx = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      id_cnt_q  <= '0;
      cur_id_q  <= '0;
      tcnt_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      awid_q    <= '0;
      arid_q    <= '0;
      awsize_q  <= '0;
      arsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      aw_done_q <= aw_done_nx;
      w_done_q  <= w_done_nx;
      id_cnt_q  <= id_cnt_nx;
      cur_id_q  <= cur_id_nx;
      tcnt_q    <= tcnt_nx;
      awvalid_q <= awvalid_nx;
      wvalid_q  <= wvalid_nx;
      bready_q  <= bready_nx;
      arvalid_q <= arvalid_nx;
      rready_q  <= rready_nx;
      awaddr_q  <= awaddr_nx;
      araddr_q  <= araddr_nx;
      awid_q    <= awid_nx;
      arid_q    <= arid_nx;
      awsize_q  <= awsize_nx;
      arsize_q  <= arsize_nx;
      wdata_q   <= wdata_nx;
      wstrb_q   <= wstrb_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
      rsp_resp  <= rsp_resp_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

endmodule

// File: tb/tb_axi_tb_mst.sv
// Directed bench for axi_tb_mst: a small behavioural AXI memory slave with knobs for
// stalls, wrong IDs, missing rlast and missing responses, driven by one linear sequence.
module tb_axi_tb_mst;

  localparam int TAGW    = 2;
  localparam int TIMEOUT = 16;

  logic        aclk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [63:0] cmd_wdata;
  logic [7:0]  cmd_wstrb;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  always #5 aclk = ~aclk;

  axi_tb_mst_if #(.TAGW(TAGW)) axi ();

  axi_tb_mst #(.TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .aclk      (aclk),
    .rst_l     (rst_l),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .rsp_err   (rsp_err),
    .axi       (axi)
  );

  int              aw_stall_cfg;
  logic            b_never, r_never, bid_ovr_en, rlast_cfg, rdata_ovr_en;
  logic [TAGW-1:0] bid_ovr_val;
  logic [1:0]      bresp_cfg;
  logic [63:0]     rdata_ovr_val;

  int              aw_stall_cnt;
  int              b_count;
  logic            aw_seen, w_seen, s_aw_hs, s_w_hs, s_aw_now, s_w_now;
  logic [31:0]     aw_addr_s, s_addr;
  logic [TAGW-1:0] aw_id_s;
  logic [63:0]     w_data_s, s_data, s_cur;
  logic [7:0]      w_strb_s, s_strb;
  logic [63:0]     mem [logic [31:0]];

  function automatic logic [63:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'd0;
  endfunction

  assign axi.awready = (aw_stall_cnt >= aw_stall_cfg);
  assign axi.wready  = 1'b1;
  assign axi.arready = 1'b1;

  // Slave responds one cycle after the request handshake(s) complete.
  always @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      aw_stall_cnt <= 0;
      b_count      <= 0;
      aw_seen      <= 1'b0;
      w_seen       <= 1'b0;
      aw_addr_s    <= '0;
      aw_id_s      <= '0;
      w_data_s     <= '0;
      w_strb_s     <= '0;
      axi.bvalid   <= 1'b0;
      axi.bresp    <= '0;
      axi.bid      <= '0;
      axi.rvalid   <= 1'b0;
      axi.rdata    <= '0;
      axi.rresp    <= '0;
      axi.rid      <= '0;
      axi.rlast    <= 1'b0;
    end else begin
      s_aw_hs  = axi.awvalid && axi.awready;
      s_w_hs   = axi.wvalid && axi.wready;
      s_aw_now = aw_seen || s_aw_hs;
      s_w_now  = w_seen || s_w_hs;
      if (axi.awvalid && !axi.awready) aw_stall_cnt <= aw_stall_cnt + 1;
      if (s_aw_hs) begin
        aw_stall_cnt <= 0;
        aw_seen      <= 1'b1;
        aw_addr_s    <= axi.awaddr;
        aw_id_s      <= axi.awid;
      end
      if (s_w_hs) begin
        w_seen   <= 1'b1;
        w_data_s <= axi.wdata;
        w_strb_s <= axi.wstrb;
      end
      if (s_aw_now && s_w_now && !axi.bvalid && !b_never) begin
        s_addr = s_aw_hs ? axi.awaddr : aw_addr_s;
        s_data = s_w_hs ? axi.wdata : w_data_s;
        s_strb = s_w_hs ? axi.wstrb : w_strb_s;
        s_cur  = memRead(s_addr);
        for (int i = 0; i < 8; i++)
          if (s_strb[i]) s_cur[i*8 +: 8] = s_data[i*8 +: 8];
        mem[s_addr] = s_cur;
        axi.bvalid <= 1'b1;
        axi.bresp  <= bresp_cfg;
        axi.bid    <= bid_ovr_en ? bid_ovr_val : (s_aw_hs ? axi.awid : aw_id_s);
        aw_seen    <= 1'b0;
        w_seen     <= 1'b0;
      end
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
        b_count    <= b_count + 1;
      end
      if (axi.arvalid && axi.arready && !r_never) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= rdata_ovr_en ? rdata_ovr_val : memRead(axi.araddr);
        axi.rresp  <= 2'b00;
        axi.rid    <= axi.arid;
        axi.rlast  <= rlast_cfg;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  int              n_checks = 0;
  int              n_fails  = 0;
  int              obs_lat, obs_aw_cyc, obs_w_cyc, obs_addr_bad;
  logic            obs_got;
  logic [TAGW-1:0] obs_awid, obs_arid;
  logic [63:0]     obs_rdata;
  logic [1:0]      obs_resp;
  logic            obs_err;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
    int waited = 0;
    @(negedge aclk);
    while (!cmd_ready && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = 3'd3;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int max_cyc, input logic [31:0] exp_addr);
    obs_lat = 0; obs_aw_cyc = 0; obs_w_cyc = 0; obs_addr_bad = 0; obs_got = 1'b0;
    obs_awid = '0; obs_arid = '0;
    while (!obs_got && obs_lat < max_cyc) begin
      @(negedge aclk);
      obs_lat++;
      if (axi.awvalid) begin
        obs_aw_cyc++;
        if (obs_aw_cyc == 1) obs_awid = axi.awid;
        if (axi.awaddr !== exp_addr) obs_addr_bad++;
      end
      if (axi.wvalid) obs_w_cyc++;
      if (axi.arvalid) obs_arid = axi.arid;
      if (rsp_valid) begin
        obs_got   = 1'b1;
        obs_rdata = rsp_rdata;
        obs_resp  = rsp_resp;
        obs_err   = rsp_err;
      end
    end
    checkOutput("rsp_seen", {63'd0, obs_got}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   b0, waited;
    logic saw;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_wdata = 0; cmd_wstrb = 0;
    aw_stall_cfg = 0; b_never = 0; r_never = 0; bid_ovr_en = 0; bid_ovr_val = 0;
    bresp_cfg = 2'b00; rlast_cfg = 1; rdata_ovr_en = 0; rdata_ovr_val = 0;

    #12;
    checkOutput("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("reset_valids", {59'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 64'd0);
    checkOutput("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset_awaddr", {32'd0, axi.awaddr}, 64'd0);
    @(negedge aclk) rst_l = 1'b1;

    applyStimulus(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    waitRsp(40, 32'h8000_0010);
    checkOutput("wr_latency", obs_lat, 3);
    checkOutput("wr_awid", obs_awid, 0);
    checkOutput("wr_resp", {obs_rdata[61:0], obs_resp}, 64'd0);
    checkOutput("wr_err", obs_err, 0);

    applyStimulus(1'b0, 32'h8000_0010, 64'd0, 8'h00);
    waitRsp(40, 32'h0);
    checkOutput("rd_latency", obs_lat, 3);
    checkOutput("rd_arid", obs_arid, 1);
    checkOutput("rd_rdata", obs_rdata, 64'h1122_3344_5566_7788);
    checkOutput("rd_resp", obs_resp, 0);
    checkOutput("rd_err", obs_err, 0);

    aw_stall_cfg = 3;
    b0 = b_count;
    applyStimulus(1'b1, 32'h8000_0020, 64'hCAFE_F00D_DEAD_BEEF, 8'h0F);
    waitRsp(40, 32'h8000_0020);
    checkOutput("bp_awvalid_cycles", obs_aw_cyc, 4);
    checkOutput("bp_wvalid_cycles", obs_w_cyc, 1);
    checkOutput("bp_awaddr_stable", obs_addr_bad, 0);
    checkOutput("bp_latency", obs_lat, 6);
    checkOutput("bp_awid", obs_awid, 2);
    repeat (3) @(negedge aclk);
    checkOutput("bp_b_count", b_count - b0, 1);
    aw_stall_cfg = 0;

    @(negedge aclk) rst_l = 1'b0;
    @(negedge aclk) rst_l = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'h8000_0010, 64'd0, 8'h00);
      waitRsp(40, 32'h0);
      checkOutput($sformatf("id_arid_%0d", k), obs_arid, k % 4);
      checkOutput($sformatf("id_rdata_%0d", k), obs_rdata, 64'h1122_3344_5566_7788);
    end
    bid_ovr_en = 1; bid_ovr_val = 2'd3; bresp_cfg = 2'b01;
    applyStimulus(1'b1, 32'h8000_0030, 64'h1, 8'h01);
    waitRsp(40, 32'h8000_0030);
    checkOutput("idchk_awid", obs_awid, 1);
    checkOutput("idchk_err", obs_err, 1);
    checkOutput("idchk_resp", obs_resp, 2'b01);
    bid_ovr_en = 0; bresp_cfg = 2'b00;

    r_never = 1;
    applyStimulus(1'b0, 32'h8000_0010, 64'd0, 8'h00);
    waitRsp(40, 32'h0);
    checkOutput("tmo_latency", obs_lat, 16);
    checkOutput("tmo_err", obs_err, 1);
    checkOutput("tmo_resp", obs_resp, 2'b10);
    checkOutput("tmo_rdata", obs_rdata, 0);
    @(negedge aclk);
    checkOutput("tmo_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    r_never = 0;

    rlast_cfg = 0; rdata_ovr_en = 1; rdata_ovr_val = 64'hAA;
    applyStimulus(1'b0, 32'h8000_0010, 64'd0, 8'h00);
    waitRsp(40, 32'h0);
    checkOutput("rlast_latency", obs_lat, 3);
    checkOutput("rlast_rdata", obs_rdata, 64'hAA);
    checkOutput("rlast_err", obs_err, 1);
    rlast_cfg = 1; rdata_ovr_en = 0;

    b_never = 1;
    applyStimulus(1'b1, 32'h8000_0040, 64'h55, 8'hFF);
    waited = 0;
    @(negedge aclk);
    while (!axi.bready && waited < 10) begin
      @(negedge aclk);
      waited++;
    end
    checkOutput("rst_bready_reached", {63'd0, axi.bready}, 64'd1);
    #2 rst_l = 1'b0;
    #1;
    checkOutput("rst_bready_async", {63'd0, axi.bready}, 64'd0);
    checkOutput("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    saw = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      saw = saw | rsp_valid;
    end
    checkOutput("rst_no_rsp", {63'd0, saw}, 64'd0);
    b_never = 0;
    rst_l = 1'b1;
    applyStimulus(1'b1, 32'h8000_0050, 64'h66, 8'hFF);
    waitRsp(40, 32'h8000_0050);
    checkOutput("rst_next_awid", obs_awid, 0);
    checkOutput("rst_next_latency", obs_lat, 3);
    checkOutput("rst_next_err", obs_err, 0);

    repeat (2) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
